reg_wb_arbiter: RTL
===================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL expose parameter REG_COUNT, default 32, number of architectural registers.
REQ-002 The block SHALL expose parameter DATA_W, default 64, register data width.
REQ-003 The block SHALL expose parameter MAX_OUT, default 3, maximum outstanding writes tracked per register.
REQ-004 Port CLK  in  1  single system clock; all state changes on rising edge.
REQ-005 Port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 Ports ALU_VALID in 1, ALU_REG in 5, ALU_DATA in DATA_W, ALU_READY out 1: ALU writeback request channel.
REQ-007 Ports MEM_VALID in 1, MEM_REG in 5, MEM_DATA in DATA_W, MEM_READY out 1: load writeback request channel.
REQ-008 Ports ISSUE_VALID in 1, ISSUE_REG in 5: decode reserves a destination register.
REQ-009 Port ISSUE_STALL  out  1  issue refused this cycle (counter saturated).
REQ-010 Ports WRITE_REG out 5, WRITE_DATA out DATA_W, REG_WRITE_ENABLE out 1: drive the register file write port directly.
REQ-011 Port PENDING  out  REG_COUNT  bit n = register n has outstanding writes.
REQ-012 Port SB_ERR  out  1  sticky: write committed to a register with zero outstanding count.

Function
REQ-013 A transfer on a channel SHALL occur on a rising edge where VALID and READY are both 1.
REQ-014 READY SHALL be combinational from VALID inputs and the priority flag only; at most one READY high per cycle.
REQ-015 Only one channel valid: that channel SHALL be granted (READY=1).
REQ-016 Both valid: the channel not granted most recently SHALL win (round-robin); priority flag updates only on a grant.
REQ-017 A continuously valid requester SHALL be granted within 2 cycles.
REQ-018 A granted write SHALL appear on WRITE_REG/WRITE_DATA with REG_WRITE_ENABLE=1 exactly one cycle after the transfer edge, for one cycle.
REQ-019 Granted write to register 0 SHALL be accepted but REG_WRITE_ENABLE SHALL stay 0 (register 0 reads as zero).
REQ-020 No grant: REG_WRITE_ENABLE SHALL be 0 next cycle; WRITE_REG/WRITE_DATA hold previous values.
REQ-021 Throughput SHALL be one write per cycle; no back-pressure from the write port.
REQ-022 Per register n>0 a 2-bit count SHALL increment on an edge with ISSUE_VALID=1, ISSUE_REG=n, ISSUE_STALL=0.
REQ-023 The count SHALL decrement on an edge where REG_WRITE_ENABLE=1 and WRITE_REG=n, so PENDING[n] clears on the same edge the file updates.
REQ-024 Increment and decrement to the same register on one edge SHALL leave the count unchanged.
REQ-025 ISSUE_STALL SHALL be 1 combinationally when ISSUE_VALID=1 and count[ISSUE_REG]=MAX_OUT; issue then ignored.
REQ-026 Issue to register 0 SHALL be ignored, never stall; PENDING[0] SHALL always be 0.
REQ-027 Decrement with count=0 SHALL leave count 0 and set SB_ERR until reset.
REQ-028 PENDING[n] SHALL equal (count[n] != 0), registered, no combinational path from inputs.

Reset
REQ-029 RST_N low SHALL immediately clear all counts, PENDING=0, REG_WRITE_ENABLE=0, WRITE_REG=0, WRITE_DATA=0, SB_ERR=0.
REQ-030 Reset SHALL set priority flag so ALU wins the first simultaneous request.
REQ-031 Reset mid-transfer SHALL drop the in-flight write (no enable after release); READY outputs remain combinational.

Structure
REQ-032 REG_COUNT, DATA_W, MAX_OUT, ZERO_REG=0 and the channel-select encoding SHALL live in the shared processor package.
REQ-033 Per-register counters SHALL be a sub-module named reg_scoreboard; arbitration and output register stay in the top.

Verification
REQ-034 ALU_VALID only, ALU_REG=5, ALU_DATA=0xA5 -> ALU_READY=1; next cycle WRITE_REG=5, WRITE_DATA=0xA5, REG_WRITE_ENABLE=1.
REQ-035 Both valid 4 cycles after reset -> grants ALU, MEM, ALU, MEM; enable high 4 consecutive cycles.
REQ-036 ISSUE reg 7 three times -> PENDING[7]=1; fourth issue -> ISSUE_STALL=1; three MEM writes to 7 -> PENDING[7]=0 on third commit edge.
REQ-037 Issue reg 9 on the edge a write to 9 commits with count=1 -> count stays 1, PENDING[9]=1.
REQ-038 MEM write to reg 0 -> MEM_READY=1, REG_WRITE_ENABLE=0; ALU write to reg 4 with count 0 -> SB_ERR=1 sticky.
REQ-039 RST_N low one cycle after grant -> no REG_WRITE_ENABLE, PENDING=0, SB_ERR=0.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared processor constants for the writeback arbiter and its register scoreboard.
package reg_wb_arbiter_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MAX_OUT   = 3;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned ZERO_REG  = 0;

  // Channel-select encoding; also the "granted most recently" flag
  typedef enum logic {
    CH_ALU = 1'b0,
    CH_MEM = 1'b1
  } ch_sel_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write counters with issue stall, pending map and sticky underflow error.
module reg_scoreboard #(
  parameter int unsigned REG_COUNT = reg_wb_arbiter_pkg::REG_COUNT,
  parameter int unsigned MAX_OUT   = reg_wb_arbiter_pkg::MAX_OUT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_issue_valid,
  input  logic [reg_wb_arbiter_pkg::REG_W-1:0]  i_issue_reg,
  input  logic                                  i_wr_en,
  input  logic [reg_wb_arbiter_pkg::REG_W-1:0]  i_wr_reg,
  output logic                                  o_stall_c,
  output logic [REG_COUNT-1:0]                  o_pending,
  output logic                                  o_err
);
  import reg_wb_arbiter_pkg::*;

  localparam int unsigned CNT_W = (MAX_OUT < 2) ? 1 : $clog2(MAX_OUT + 1);

  logic [CNT_W-1:0]     r_count [REG_COUNT];
  logic [CNT_W-1:0]     w_count_nxt [REG_COUNT];
  logic [REG_COUNT-1:0] r_pending;
  logic [REG_COUNT-1:0] w_pending_nxt;
  logic [REG_COUNT-1:0] w_inc_vec;
  logic [REG_COUNT-1:0] w_dec_vec;
  logic                 r_err;
  logic                 w_err_set;
  logic                 w_issue_hit;
  logic                 w_inc;

  assign w_issue_hit = i_issue_valid && (i_issue_reg != REG_W'(ZERO_REG));
  assign o_stall_c   = w_issue_hit && (r_count[i_issue_reg] == CNT_W'(MAX_OUT));
  assign w_inc       = w_issue_hit && !o_stall_c;

  // One-hot increment/decrement requests; register 0 never tracked
  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    for (int n = 1; n < int'(REG_COUNT); n++) begin
      w_inc_vec[n] = w_inc && (i_issue_reg == REG_W'(n));
      w_dec_vec[n] = i_wr_en && (i_wr_reg == REG_W'(n));
    end
  end

  always_comb begin
    w_err_set     = 1'b0;
    w_pending_nxt = '0;
    for (int n = 0; n < int'(REG_COUNT); n++) begin
      w_count_nxt[n] = r_count[n];
      if (w_dec_vec[n] && (r_count[n] == '0)) begin
        w_err_set = 1'b1;
      end
      if (w_inc_vec[n] && !w_dec_vec[n]) begin
        w_count_nxt[n] = r_count[n] + CNT_W'(1);
      end else if (w_dec_vec[n] && !w_inc_vec[n] && (r_count[n] != '0)) begin
        w_count_nxt[n] = r_count[n] - CNT_W'(1);
      end
      w_pending_nxt[n] = (w_count_nxt[n] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < int'(REG_COUNT); n++) begin
        r_count[n] <= '0;
      end
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      for (int n = 0; n < int'(REG_COUNT); n++) begin
        r_count[n] <= w_count_nxt[n];
      end
      r_pending <= w_pending_nxt;
      r_err     <= r_err | w_err_set;
    end
  end

  assign o_pending = r_pending;
  assign o_err     = r_err;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin ALU/MEM writeback arbiter driving the register-file write port, with scoreboard.
module reg_wb_arbiter #(
  parameter int unsigned REG_COUNT = reg_wb_arbiter_pkg::REG_COUNT,
  parameter int unsigned DATA_W    = reg_wb_arbiter_pkg::DATA_W,
  parameter int unsigned MAX_OUT   = reg_wb_arbiter_pkg::MAX_OUT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_alu_valid,
  input  logic [reg_wb_arbiter_pkg::REG_W-1:0]  i_alu_reg,
  input  logic [DATA_W-1:0]                     i_alu_data,
  output logic                                  o_alu_ready_c,
  input  logic                                  i_mem_valid,
  input  logic [reg_wb_arbiter_pkg::REG_W-1:0]  i_mem_reg,
  input  logic [DATA_W-1:0]                     i_mem_data,
  output logic                                  o_mem_ready_c,
  input  logic                                  i_issue_valid,
  input  logic [reg_wb_arbiter_pkg::REG_W-1:0]  i_issue_reg,
  output logic                                  o_issue_stall_c,
  output logic [reg_wb_arbiter_pkg::REG_W-1:0]  o_write_reg,
  output logic [DATA_W-1:0]                     o_write_data,
  output logic                                  o_reg_write_enable,
  output logic [REG_COUNT-1:0]                  o_pending,
  output logic                                  o_sb_err
);
  import reg_wb_arbiter_pkg::*;

  ch_sel_e           r_last_grant;
  logic              w_alu_grant;
  logic              w_mem_grant;
  logic              r_we;
  logic [REG_W-1:0]  r_write_reg;
  logic [DATA_W-1:0] r_write_data;

  // Contention goes to the channel not granted most recently
  always_comb begin
    w_alu_grant = i_alu_valid;
    w_mem_grant = i_mem_valid;
    if (i_alu_valid && i_mem_valid) begin
      w_alu_grant = (r_last_grant == CH_MEM);
      w_mem_grant = (r_last_grant == CH_ALU);
    end
  end

  assign o_alu_ready_c = w_alu_grant;
  assign o_mem_ready_c = w_mem_grant;

  // Write-port register; register 0 writes are accepted but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= CH_MEM;
      r_we         <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_alu_grant) begin
      r_last_grant <= CH_ALU;
      r_we         <= (i_alu_reg != REG_W'(ZERO_REG));
      r_write_reg  <= i_alu_reg;
      r_write_data <= i_alu_data;
    end else if (w_mem_grant) begin
      r_last_grant <= CH_MEM;
      r_we         <= (i_mem_reg != REG_W'(ZERO_REG));
      r_write_reg  <= i_mem_reg;
      r_write_data <= i_mem_data;
    end else begin
      r_we         <= 1'b0;
    end
  end

  assign o_reg_write_enable = r_we;
  assign o_write_reg        = r_write_reg;
  assign o_write_data       = r_write_data;

  reg_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .MAX_OUT   (MAX_OUT)
  ) u_reg_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue_valid (i_issue_valid),
    .i_issue_reg   (i_issue_reg),
    .i_wr_en       (r_we),
    .i_wr_reg      (r_write_reg),
    .o_stall_c     (o_issue_stall_c),
    .o_pending     (o_pending),
    .o_err         (o_sb_err)
  );

endmodule
